// File: rtl/tile_instr_sequencer.sv
// Per-tile instruction sequencer. Holds a small program of 64-bit tile
// instructions and drives them onto the tile's instruction bus, one word
// per clock. A run starts with a register-clear word, can be stalled,
// repeats the program loop_cnt extra times and ends with a done pulse.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | bus carries NOP, program memory writable, waits for start
// RUN   | issues program words (or NOP while stalled)
// DRAIN | last word has been issued; issue NOP, pulse done, go IDLE
module tile_instr_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [63:0]   load_data,
    input  logic [AW:0]   prog_len,
    input  logic [7:0]    loop_cnt,
    input  logic          start,
    input  logic          stall,
    output logic [63:0]   instruction,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done,
    output logic          load_err
);

    localparam logic [63:0] NOP = 64'h0000_0000_0000_0007;
    localparam logic [63:0] CLR = 64'h2000_0000_0000_0007;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state;
    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] last_pc;
    logic [7:0]    loops;
    logic [7:0]    pass;
    logic          len_ok;

    // A zero-length or oversized program is not runnable; such starts are dropped.
    assign len_ok = (prog_len != '0) && (prog_len <= (AW+1)'(DEPTH));

    // Program memory: written only while idle, never reset so programs survive rst.
    always_ff @(posedge clk) begin
        if (load_en && (state == IDLE)) begin
            mem[load_addr] <= load_data;
        end
    end

    // Sequencer FSM; every output is registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            instruction <= NOP;
            pc          <= '0;
            last_pc     <= '0;
            loops       <= '0;
            pass        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            done     <= 1'b0;
            load_err <= load_en && (state != IDLE);
            case (state)
                IDLE: begin
                    instruction <= NOP;
                    pc          <= '0;
                    if (start && len_ok) begin
                        last_pc     <= AW'(prog_len - 1'b1);
                        loops       <= loop_cnt;
                        pass        <= '0;
                        instruction <= CLR;
                        busy        <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (stall) begin
                        instruction <= NOP;
                    end else begin
                        instruction <= mem[pc];
                        if (pc != last_pc) begin
                            pc <= pc + 1'b1;
                        end else begin
                            pc <= '0;
                            if (pass == loops) begin
                                state <= DRAIN;
                            end else begin
                                pass <= pass + 1'b1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    instruction <= NOP;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    pc          <= '0;
                    state       <= IDLE;
                end
                default: begin
                    instruction <= NOP;
                    busy        <= 1'b0;
                    pc          <= '0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
